sa_rdata_router: RTL and testbench
==================================

// Module: sa_rdata_router
// PURPOSE
//  Slave-side R-channel router for one interconnect slave port. Steers R beats to MST_AMT dispatchers by RID master field.
//  Merges 4KB-split sub-bursts back into one master burst by suppressing the intermediate RLASTs; a split may have multiple sub-bursts.
//  Optional per-master 2-entry skid buffer (PIPE_EN=1) breaks the RREADY->s_RREADY timing path; no head-of-line blocking between masters.
// PARAMETERS
//  MST_AMT          3                             number of masters (dispatchers)
//  OUTSTANDING_AMT  8                             split-tracking FIFO depth (power of 2)
//  MST_ID_W         $clog2(MST_AMT)               master-select field width
//  DATA_WIDTH       32                            RDATA width
//  TRANS_MST_ID_W   5                             master-side transaction ID width
//  TRANS_SLV_ID_W   TRANS_MST_ID_W+MST_ID_W       slave-side transaction ID width
//  TRANS_RESP_W     2                             RRESP width
//  SPLIT_CNT_W      3                             width of sub-burst crossing count
//  PIPE_EN          1                             1: skid buffers (1-cycle latency); 0: combinational pass-through
// PORTS
//  ACLK_i           in   1                        clock, all state on rising edge
//  ARESET_i         in   1                        asynchronous, active-high reset
//  dsp_RREADY_i     in   MST_AMT                  per-master RREADY
//  s_RID_i          in   TRANS_SLV_ID_W           slave RID; MSBs [TRANS_SLV_ID_W-1 -: MST_ID_W] = master index
//  s_RDATA_i        in   DATA_WIDTH               slave RDATA
//  s_RRESP_i        in   TRANS_RESP_W             slave RRESP
//  s_RLAST_i        in   1                        slave RLAST (end of sub-burst)
//  s_RVALID_i       in   1                        slave RVALID
//  AR_AxID_i        in   TRANS_SLV_ID_W           ID of AR being issued
//  AR_crossing_flag_i in 1                        issued AR is split
//  AR_split_amt_i   in   SPLIT_CNT_W              boundary crossings of that AR (>=1 when flag=1)
//  AR_shift_en_i    in   1                        AR issued this cycle
//  dsp_RID_o        out  TRANS_MST_ID_W*MST_AMT   per-master RID (low TRANS_MST_ID_W bits of RID)
//  dsp_RDATA_o      out  DATA_WIDTH*MST_AMT       per-master RDATA
//  dsp_RRESP_o      out  TRANS_RESP_W*MST_AMT     per-master RRESP
//  dsp_RLAST_o      out  MST_AMT                  per-master filtered RLAST
//  dsp_RVALID_o     out  MST_AMT                  per-master RVALID
//  s_RREADY_o       out  1                        slave RREADY
//  AR_stall_o       out  1                        split FIFO full; AR must not issue a split
//  route_err_o      out  1                        1-cycle pulse: beat with master index >= MST_AMT dropped
// BEHAVIOUR
//  Reset: FIFO empty, split counter 0, skid buffers empty. dsp_RVALID_o=0, dsp_RLAST_o=0, dsp data/ID/RESP=0.
//    route_err_o=0, AR_stall_o=0. Reset mid-burst discards all held beats and split entries.
//  Handshake: slave beat accepted when s_RVALID_i & s_RREADY_o.
//    s_RREADY_o = target master ready: skid not full (PIPE_EN=1) or dsp_RREADY_i[mst] (PIPE_EN=0).
//    Invalid index: s_RREADY_o=1, beat dropped, route_err_o pulses next cycle.
//  Split FIFO: entry {AxID, split_amt}; push on AR_shift_en_i & AR_crossing_flag_i & ~full.
//    Push when full is ignored. AR_stall_o = full (combinational from count).
//  RLAST filter: match = ~empty & (head.ID == s_RID_i).
//    On an accepted beat with s_RLAST_i & match: RLAST suppressed (forwarded as 0).
//      If split_cnt == head.amt-1: pop, split_cnt<=0. Else split_cnt++.
//    Final sub-burst's RLAST (no match) is forwarded as 1. Non-matching IDs pass RLAST unchanged.
//  Simultaneous push+pop: allowed, count unchanged; push when full is accepted if a pop occurs in the same cycle.
//  Skid buffer (per master, depth 2): load on accepted beat, unload on dsp_RVALID_o & dsp_RREADY_i.
//    Outputs driven from head register. Latency slave->master = 1 cycle; full throughput at 1 beat/cycle per master.
//    Simultaneous load+unload with count 2 cannot occur (not ready); with count 1 count stays 1.
//  Output ordering per master preserved. dsp_RVALID_o held stable with payload until accepted (AXI rule).
//  PIPE_EN=0: dsp_RVALID_o[i] = s_RVALID_i & (mst==i) & valid index; payload broadcast; zero latency.
// TESTING
//  T1 reset: assert ARESET_i mid-burst with 2 beats buffered -> all dsp_RVALID_o=0 same cycle; FIFO empty; AR_stall_o=0.
//  T2 route: RID=0x25 (mst 1), RDATA=0xDEADBEEF, all ready -> dsp_RVALID_o=3'b010 next cycle;
//     dsp_RID_o[1]=0x05; other masters idle.
//  T3 split x2: push ID 0x12 amt=2; three 4-beat sub-bursts, RLAST each ->
//     master sees 12 beats, RLAST only on beat 12; FIFO pops on beat 8.
//  T4 full: push 8 splits -> AR_stall_o=1; same-cycle push+pop -> count stays 8; ninth push without pop ignored.
//  T5 backpressure: dsp_RREADY_i[0]=0, 3 beats to mst 0 -> s_RREADY_o low after 2 accepted;
//     a beat to mst 2 is still accepted once RID switches.
//  T6 bad index: MST_AMT=3, RID master field=3 -> s_RREADY_o=1, no dsp_RVALID_o, route_err_o=1 for one cycle.

Source files
------------

// File: rtl/sa_rdata_router.sv
// Slave-side R-channel router: steers R beats to per-master dispatchers by the RID master field
// and merges 4KB-split sub-bursts by suppressing intermediate RLASTs.
module sa_rdata_router #(
  parameter int MST_AMT         = 3,
  parameter int OUTSTANDING_AMT = 8,
  parameter int MST_ID_W        = $clog2(MST_AMT),
  parameter int DATA_WIDTH      = 32,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_RESP_W    = 2,
  parameter int SPLIT_CNT_W     = 3,
  parameter bit PIPE_EN         = 1'b1
) (
  input  logic                               ACLK_i,
  input  logic                               ARESET_i,
  input  logic [MST_AMT-1:0]                 dsp_RREADY_i,
  input  logic [TRANS_SLV_ID_W-1:0]          s_RID_i,
  input  logic [DATA_WIDTH-1:0]              s_RDATA_i,
  input  logic [TRANS_RESP_W-1:0]            s_RRESP_i,
  input  logic                               s_RLAST_i,
  input  logic                               s_RVALID_i,
  input  logic [TRANS_SLV_ID_W-1:0]          AR_AxID_i,
  input  logic                               AR_crossing_flag_i,
  input  logic [SPLIT_CNT_W-1:0]             AR_split_amt_i,
  input  logic                               AR_shift_en_i,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]  dsp_RID_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]      dsp_RDATA_o,
  output logic [TRANS_RESP_W*MST_AMT-1:0]    dsp_RRESP_o,
  output logic [MST_AMT-1:0]                 dsp_RLAST_o,
  output logic [MST_AMT-1:0]                 dsp_RVALID_o,
  output logic                               s_RREADY_o,
  output logic                               AR_stall_o,
  output logic                               route_err_o
);

  localparam int PTR_W = $clog2(OUTSTANDING_AMT);
  localparam int PAY_W = TRANS_MST_ID_W + DATA_WIDTH + TRANS_RESP_W + 1;

  logic [MST_ID_W-1:0]       mst_idx;
  logic [MST_AMT-1:0]        mst_sel;
  logic [MST_AMT-1:0]        skid_rdy;
  logic                      idx_ok;
  logic                      beat_acc;
  logic                      beat_ok;
  logic [PAY_W-1:0]          beat_pay;

  logic [TRANS_SLV_ID_W-1:0] fifo_id  [OUTSTANDING_AMT];
  logic [SPLIT_CNT_W-1:0]    fifo_amt [OUTSTANDING_AMT];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W:0]            fifo_cnt;
  logic [SPLIT_CNT_W-1:0]    split_cnt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      id_match;
  logic                      last_hit;
  logic                      fifo_pop;
  logic                      fifo_push;
  logic                      last_fwd;

  assign mst_idx = s_RID_i[TRANS_SLV_ID_W-1 -: MST_ID_W];

  always_comb begin
    mst_sel = '0;
    for (int i = 0; i < MST_AMT; i++)
      mst_sel[i] = (mst_idx == MST_ID_W'(i));
  end

  // An out-of-range master index selects nobody; the beat is swallowed so the slave never stalls.
  assign idx_ok     = |mst_sel;
  assign s_RREADY_o = idx_ok ? |(mst_sel & skid_rdy) : 1'b1;
  assign beat_acc   = s_RVALID_i & s_RREADY_o;
  assign beat_ok    = beat_acc & idx_ok;

  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(OUTSTANDING_AMT));
  assign fifo_empty = (fifo_cnt == '0);
  assign id_match   = ~fifo_empty & (fifo_id[rd_ptr] == s_RID_i);
  assign last_hit   = beat_ok & s_RLAST_i & id_match;
  assign fifo_pop   = last_hit & (split_cnt == (fifo_amt[rd_ptr] - SPLIT_CNT_W'(1)));
  assign fifo_push  = AR_shift_en_i & AR_crossing_flag_i & (~fifo_full | fifo_pop);
  assign AR_stall_o = fifo_full;
  assign last_fwd   = s_RLAST_i & ~id_match;

  assign beat_pay = {s_RID_i[TRANS_MST_ID_W-1:0], s_RDATA_i, s_RRESP_i, last_fwd};

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      split_cnt <= '0;
    end else begin
      if (fifo_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        split_cnt <= '0;
      end else if (last_hit) begin
        split_cnt <= split_cnt + SPLIT_CNT_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (fifo_push) begin
      fifo_id[wr_ptr]  <= AR_AxID_i;
      fifo_amt[wr_ptr] <= AR_split_amt_i;
    end
  end

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i)
      route_err_o <= 1'b0;
    else
      route_err_o <= s_RVALID_i & ~idx_ok;
  end

  if (PIPE_EN) begin : g_skid
    for (genvar g = 0; g < MST_AMT; g++) begin : g_mst
      logic [PAY_W-1:0] head_p1;
      logic [PAY_W-1:0] tail_p1;
      logic [1:0]       cnt_p1;
      logic             load;
      logic             unload;

      assign load        = beat_ok & mst_sel[g];
      assign unload      = (cnt_p1 != 2'd0) & dsp_RREADY_i[g];
      assign skid_rdy[g] = (cnt_p1 != 2'd2);

      // p0 -> p1: slave beat lands in the per-master skid, head drives the dispatcher
      always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
          head_p1 <= '0;
          tail_p1 <= '0;
          cnt_p1  <= 2'd0;
        end else begin
          case ({load, unload})
            2'b10: begin
              if (cnt_p1 == 2'd0)
                head_p1 <= beat_pay;
              else
                tail_p1 <= beat_pay;
              cnt_p1 <= cnt_p1 + 2'd1;
            end
            2'b01: begin
              head_p1 <= tail_p1;
              cnt_p1  <= cnt_p1 - 2'd1;
            end
            2'b11: begin
              if (cnt_p1 == 2'd2) begin
                head_p1 <= tail_p1;
                tail_p1 <= beat_pay;
              end else begin
                head_p1 <= beat_pay;
              end
            end
            default: ;
          endcase
        end
      end

      assign dsp_RVALID_o[g] = (cnt_p1 != 2'd0);
      assign {dsp_RID_o[g*TRANS_MST_ID_W +: TRANS_MST_ID_W],
              dsp_RDATA_o[g*DATA_WIDTH +: DATA_WIDTH],
              dsp_RRESP_o[g*TRANS_RESP_W +: TRANS_RESP_W],
              dsp_RLAST_o[g]} = head_p1;
    end
  end else begin : g_pass
    assign skid_rdy = dsp_RREADY_i;
    for (genvar g = 0; g < MST_AMT; g++) begin : g_mst
      assign dsp_RVALID_o[g] = s_RVALID_i & mst_sel[g];
      assign {dsp_RID_o[g*TRANS_MST_ID_W +: TRANS_MST_ID_W],
              dsp_RDATA_o[g*DATA_WIDTH +: DATA_WIDTH],
              dsp_RRESP_o[g*TRANS_RESP_W +: TRANS_RESP_W],
              dsp_RLAST_o[g]} = beat_pay;
    end
  end

endmodule

// File: tb/tb_sa_rdata_router.sv
// Directed bench for sa_rdata_router: routing, split RLAST merging, FIFO full, backpressure, reset.
module tb_sa_rdata_router;

  localparam int MA = 3;
  localparam int DW = 32;
  localparam int MW = 5;
  localparam int SW = 7;
  localparam int RW = 2;
  localparam int CW = 3;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [MA-1:0]     dsp_RREADY = '1;
  logic [SW-1:0]     s_RID = '0;
  logic [DW-1:0]     s_RDATA = '0;
  logic [RW-1:0]     s_RRESP = '0;
  logic              s_RLAST = 1'b0;
  logic              s_RVALID = 1'b0;
  logic [SW-1:0]     AR_AxID = '0;
  logic              AR_flag = 1'b0;
  logic [CW-1:0]     AR_amt = '0;
  logic              AR_shift = 1'b0;
  logic [MW*MA-1:0]  dsp_RID;
  logic [DW*MA-1:0]  dsp_RDATA;
  logic [RW*MA-1:0]  dsp_RRESP;
  logic [MA-1:0]     dsp_RLAST;
  logic [MA-1:0]     dsp_RVALID;
  logic              s_RREADY;
  logic              AR_stall;
  logic              route_err;

  int n_checks = 0;
  int n_err    = 0;

  sa_rdata_router dut (
    .ACLK_i             (ACLK),
    .ARESET_i           (ARESET),
    .dsp_RREADY_i       (dsp_RREADY),
    .s_RID_i            (s_RID),
    .s_RDATA_i          (s_RDATA),
    .s_RRESP_i          (s_RRESP),
    .s_RLAST_i          (s_RLAST),
    .s_RVALID_i         (s_RVALID),
    .AR_AxID_i          (AR_AxID),
    .AR_crossing_flag_i (AR_flag),
    .AR_split_amt_i     (AR_amt),
    .AR_shift_en_i      (AR_shift),
    .dsp_RID_o          (dsp_RID),
    .dsp_RDATA_o        (dsp_RDATA),
    .dsp_RRESP_o        (dsp_RRESP),
    .dsp_RLAST_o        (dsp_RLAST),
    .dsp_RVALID_o       (dsp_RVALID),
    .s_RREADY_o         (s_RREADY),
    .AR_stall_o         (AR_stall),
    .route_err_o        (route_err)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [SW-1:0] rid;
    logic [DW-1:0] data;
    logic          last;
    logic          vld;
    logic [MA-1:0] rdy;
    logic          exp_srdy;
    logic [MA-1:0] exp_vld;
    logic [MA-1:0] exp_last;
    logic          exp_err;
    int            m;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [SW-1:0] rid, logic [DW-1:0] data, logic last, logic vld,
                              logic exp_srdy, logic [MA-1:0] exp_vld, logic [MA-1:0] exp_last,
                              logic exp_err, int m);
    vec_t v;
    v.rid = rid; v.data = data; v.last = last; v.vld = vld; v.rdy = '1;
    v.exp_srdy = exp_srdy; v.exp_vld = exp_vld; v.exp_last = exp_last;
    v.exp_err = exp_err; v.m = m;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic ar_push(input logic [SW-1:0] id, input logic [CW-1:0] amt);
    AR_AxID = id; AR_amt = amt; AR_flag = 1'b1; AR_shift = 1'b1;
    tick();
    AR_flag = 1'b0; AR_shift = 1'b0;
  endtask

  task automatic beat(input logic [SW-1:0] rid, input logic [DW-1:0] d, input logic l);
    s_RID = rid; s_RDATA = d; s_RLAST = l; s_RVALID = 1'b1;
  endtask

  task automatic idle();
    s_RVALID = 1'b0; s_RLAST = 1'b0; s_RID = '0;
  endtask

  initial begin
    // Vector table: route, split merge (ID 0x12 split twice), bad index
    tbl.push_back(mk(7'h25, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 3'b010, 3'b010, 1'b0, 1));
    tbl.push_back(mk(7'h00, 32'h0,        1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, -1));
    tbl.push_back(mk(7'h45, 32'hA5A50001, 1'b0, 1'b1, 1'b1, 3'b100, 3'b000, 1'b0, 2));
    for (int k = 1; k <= 12; k++)
      tbl.push_back(mk(7'h12, 32'h1000 + DW'(k), (k % 4) == 0, 1'b1, 1'b1, 3'b001,
                       (k == 12) ? 3'b001 : 3'b000, 1'b0, 0));
    tbl.push_back(mk(7'h60, 32'hBADBAD00, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1, -1));
    tbl.push_back(mk(7'h00, 32'h0,        1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, -1));
    tbl.push_back(mk(7'h12, 32'h00C0FFEE, 1'b1, 1'b1, 1'b1, 3'b001, 3'b001, 1'b0, 0));

    #2;
    chk("rst_vld",   64'(dsp_RVALID), 64'(0));
    chk("rst_last",  64'(dsp_RLAST),  64'(0));
    chk("rst_data",  64'(dsp_RDATA),  64'(0));
    chk("rst_rid",   64'(dsp_RID),    64'(0));
    chk("rst_stall", 64'(AR_stall),   64'(0));
    chk("rst_err",   64'(route_err),  64'(0));
    tick();
    tick();
    ARESET = 1'b0;
    tick();

    ar_push(7'h12, 3'd2);

    for (int k = 0; k < tbl.size(); k++) begin
      dsp_RREADY = tbl[k].rdy;
      s_RID = tbl[k].rid; s_RDATA = tbl[k].data; s_RLAST = tbl[k].last; s_RVALID = tbl[k].vld;
      #1;
      chk($sformatf("tbl%0d_srdy", k), 64'(s_RREADY), 64'(tbl[k].exp_srdy));
      tick();
      chk($sformatf("tbl%0d_vld", k),  64'(dsp_RVALID), 64'(tbl[k].exp_vld));
      chk($sformatf("tbl%0d_last", k), 64'(dsp_RLAST & dsp_RVALID), 64'(tbl[k].exp_last));
      chk($sformatf("tbl%0d_err", k),  64'(route_err), 64'(tbl[k].exp_err));
      if (tbl[k].m >= 0) begin
        chk($sformatf("tbl%0d_rid", k),  64'(dsp_RID[tbl[k].m*MW +: MW]), 64'(tbl[k].rid[MW-1:0]));
        chk($sformatf("tbl%0d_data", k), 64'(dsp_RDATA[tbl[k].m*DW +: DW]), 64'(tbl[k].data));
      end
    end
    idle();
    tick();

    // FIFO full, push+pop at full, ignored push at full
    for (int k = 0; k < 8; k++) begin
      ar_push(7'h20 + SW'(k), 3'd1);
      chk($sformatf("full_stall%0d", k), 64'(AR_stall), 64'(k == 7));
    end
    AR_AxID = 7'h28; AR_amt = 3'd1; AR_flag = 1'b1; AR_shift = 1'b1;
    beat(7'h20, 32'h20, 1'b1);
    #1;
    chk("pushpop_srdy", 64'(s_RREADY), 64'(1));
    tick();
    AR_flag = 1'b0; AR_shift = 1'b0;
    idle();
    chk("pushpop_stall", 64'(AR_stall), 64'(1));
    chk("pushpop_vld",   64'(dsp_RVALID), 64'(3'b010));
    chk("pushpop_last",  64'(dsp_RLAST & dsp_RVALID), 64'(0));
    ar_push(7'h29, 3'd1);
    chk("ignored_push_stall", 64'(AR_stall), 64'(1));
    for (int k = 1; k <= 8; k++) begin
      beat(7'h20 + SW'(k), 32'h20 + DW'(k), 1'b1);
      tick();
      chk($sformatf("drain%0d_last", k), 64'(dsp_RLAST & dsp_RVALID), 64'(0));
      if (k == 1)
        chk("drain_stall", 64'(AR_stall), 64'(0));
    end
    beat(7'h29, 32'h29, 1'b1);
    tick();
    chk("ignored_id_last", 64'(dsp_RLAST & dsp_RVALID), 64'(3'b010));
    idle();
    tick();

    // Backpressure on master 0, master 2 still flows
    dsp_RREADY = 3'b110;
    beat(7'h01, 32'hB0, 1'b0);
    #1;
    chk("bp_srdy0", 64'(s_RREADY), 64'(1));
    tick();
    chk("bp_vld0",  64'(dsp_RVALID), 64'(3'b001));
    chk("bp_data0", 64'(dsp_RDATA[DW-1:0]), 64'(32'hB0));
    beat(7'h01, 32'hB1, 1'b0);
    #1;
    chk("bp_srdy1", 64'(s_RREADY), 64'(1));
    tick();
    beat(7'h01, 32'hB2, 1'b0);
    #1;
    chk("bp_srdy2", 64'(s_RREADY), 64'(0));
    tick();
    chk("bp_hold_data", 64'(dsp_RDATA[DW-1:0]), 64'(32'hB0));
    beat(7'h41, 32'hC0, 1'b0);
    #1;
    chk("bp_srdy_m2", 64'(s_RREADY), 64'(1));
    tick();
    chk("bp_vld_m2",  64'(dsp_RVALID), 64'(3'b101));
    chk("bp_data_m2", 64'(dsp_RDATA[2*DW +: DW]), 64'(32'hC0));
    idle();
    dsp_RREADY = 3'b111;
    tick();
    chk("bp_order_vld",  64'(dsp_RVALID), 64'(3'b001));
    chk("bp_order_data", 64'(dsp_RDATA[DW-1:0]), 64'(32'hB1));
    tick();
    chk("bp_empty_vld", 64'(dsp_RVALID), 64'(0));

    // Reset mid-burst with two beats buffered and a split outstanding
    dsp_RREADY = 3'b110;
    ar_push(7'h33, 3'd1);
    beat(7'h02, 32'hD0, 1'b0);
    tick();
    beat(7'h02, 32'hD1, 1'b0);
    tick();
    idle();
    chk("pre_rst_vld", 64'(dsp_RVALID), 64'(3'b001));
    #3;
    ARESET = 1'b1;
    #1;
    chk("mid_rst_vld",   64'(dsp_RVALID), 64'(0));
    chk("mid_rst_data",  64'(dsp_RDATA),  64'(0));
    chk("mid_rst_stall", 64'(AR_stall),   64'(0));
    tick();
    ARESET = 1'b0;
    dsp_RREADY = 3'b111;
    tick();
    chk("post_rst_vld", 64'(dsp_RVALID), 64'(0));
    beat(7'h33, 32'hE0, 1'b1);
    tick();
    chk("post_rst_last", 64'(dsp_RLAST & dsp_RVALID), 64'(3'b010));
    idle();
    tick();
    chk("post_rst_idle", 64'(dsp_RVALID), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
